// File: rtl/shift_register_ctrl_if.sv
// Word handshake between a producer and shift_register_ctrl.
// Producer drives in_data/in_valid; the controller answers with in_ready.
interface shift_register_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/shift_register_ctrl.sv
// Load/shift sequencer for a parallel-load shift register, MSB-first.
// SR_CTRL_BACKTOBACK_EN: accept the next word in the last SHIFT cycle.
module shift_register_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_register_ctrl_if.slave word,
  output logic                 sr_load,
  output logic                 sr_shift_en,
  output logic [WIDTH-1:0]     sr_pdata,
  output logic                 busy,
  output logic                 frame,
  output logic                 done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t           state;
  state_t           next;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] pdata;
  logic             done_q;
  logic             tick;
  logic             last;
  logic             hs;
  logic             ready;

  assign tick = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign last = tick && (bit_cnt == BIT_LAST);
  assign hs   = word.in_valid && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (hs) next = LOAD;
      LOAD:    next = SHIFT;
      SHIFT: begin
        // hs can only be true here in back-to-back builds
        if (last) next = hs ? LOAD : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sr_load     = 1'b0;
    sr_shift_en = 1'b0;
    busy        = 1'b1;
    frame       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      LOAD: begin
        sr_load = 1'b1;
      end
      SHIFT: begin
        frame       = 1'b1;
        sr_shift_en = tick;
`ifdef SR_CTRL_BACKTOBACK_EN
        ready       = last;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      pdata   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (hs) pdata <= word.in_data;
      if (state == LOAD) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (tick) begin
          div_cnt <= '0;
          bit_cnt <= last ? '0 : bit_cnt + BW'(1);
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

  assign word.in_ready = ready;
  assign sr_pdata      = pdata;
  assign done          = done_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench: three controllers (DIV 4, 2, 1) feeding shift register
// models that load PDATA, shift in 1s and expose SO = MSB.
module tb_shift_register_ctrl;

  typedef struct packed {
    logic       ready;
    logic       load;
    logic       shift;
    logic       busy;
    logic       frame;
    logic       done;
    logic       so;
    logic [7:0] pdata;
  } obs_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    obs_t       exp;
  } vec_t;

  localparam obs_t RST_OBS = '{ready: 1'b1, load: 1'b0, shift: 1'b0,
                               busy: 1'b0, frame: 1'b0, done: 1'b0,
                               so: 1'b1, pdata: 8'h00};
`ifdef SR_CTRL_BACKTOBACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  int         checks = 0;
  int         errors = 0;

  logic       ld  [3];
  logic       sh  [3];
  logic [7:0] pd  [3];
  logic       bsy [3];
  logic       frm [3];
  logic       dn  [3];
  logic       rdy [3];
  logic [7:0] q   [3];
  obs_t       obs [3];

  always #5 clk = ~clk;

  shift_register_ctrl_if #(.WIDTH(8)) bus0 ();
  shift_register_ctrl_if #(.WIDTH(8)) bus1 ();
  shift_register_ctrl_if #(.WIDTH(8)) bus2 ();

  assign bus0.in_data  = data;
  assign bus0.in_valid = valid;
  assign bus1.in_data  = data;
  assign bus1.in_valid = valid;
  assign bus2.in_data  = data;
  assign bus2.in_valid = valid;
  assign rdy[0] = bus0.in_ready;
  assign rdy[1] = bus1.in_ready;
  assign rdy[2] = bus2.in_ready;

  shift_register_ctrl #(.WIDTH(8), .DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .word(bus0.slave),
    .sr_load(ld[0]), .sr_shift_en(sh[0]), .sr_pdata(pd[0]),
    .busy(bsy[0]), .frame(frm[0]), .done(dn[0])
  );

  shift_register_ctrl #(.WIDTH(8), .DIV(2)) u2 (
    .clk(clk), .rst_n(rst_n), .word(bus1.slave),
    .sr_load(ld[1]), .sr_shift_en(sh[1]), .sr_pdata(pd[1]),
    .busy(bsy[1]), .frame(frm[1]), .done(dn[1])
  );

  shift_register_ctrl #(.WIDTH(8), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .word(bus2.slave),
    .sr_load(ld[2]), .sr_shift_en(sh[2]), .sr_pdata(pd[2]),
    .busy(bsy[2]), .frame(frm[2]), .done(dn[2])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n)     q[i] <= 8'hFF;
      else if (ld[i]) q[i] <= pd[i];
      else if (sh[i]) q[i] <= {q[i][6:0], 1'b1};
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      obs[i] = '{ready: rdy[i], load: ld[i], shift: sh[i],
                 busy: bsy[i], frame: frm[i], done: dn[i],
                 so: q[i][7], pdata: pd[i]};
    end
  end

  // k = edges since the handshake edge; outputs seen after that edge
  function automatic obs_t exp_obs(int div, logic [7:0] d, int k);
    obs_t e;
    int   t;
    e = '{ready: 1'b0, load: 1'b0, shift: 1'b0, busy: 1'b1,
          frame: 1'b0, done: 1'b0, so: 1'b1, pdata: d};
    t = k - 1;
    if (k == 0) begin
      e.load = 1'b1;
    end else if (k <= 8 * div) begin
      e.frame = 1'b1;
      e.shift = ((t % div) == div - 1);
      e.so    = d[7 - t / div];
`ifdef SR_CTRL_BACKTOBACK_EN
      e.ready = (t == 8 * div - 1);
`endif
    end else begin
      e.ready = 1'b1;
      e.busy  = 1'b0;
      e.done  = (k == 8 * div + 1);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string name, int k, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %h want %h", name, k, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic word_seq(string name, int sel, int div, logic [7:0] d);
    int frames;
    frames = 0;
    valid  = 1'b1;
    data   = d;
    for (int k = 0; k <= 8 * div + 2; k++) begin
      step();
      check(name, k, obs[sel], exp_obs(div, d, k));
      if (obs[sel].frame) frames++;
      if (k == 0) begin
        valid = 1'b0;
        data  = ~d;
      end
    end
    checks++;
    if (frames != 8 * div) begin
      errors++;
      $display("FAIL %s_frame_len got %0d want %0d", name, frames, 8 * div);
    end
  endtask

  vec_t vec [35];

  initial begin
    int   l2;
    obs_t e;

    for (int k = 0; k < 35; k++) begin
      vec[k].valid = (k == 0) || (k <= 32 && k[0]);
      vec[k].data  = (k == 0) ? 8'h59 : 8'(k * 37);
      vec[k].exp   = exp_obs(4, 8'h59, k);
    end

    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < 3; i++) check("reset", c, obs[i], RST_OBS);
    end

    rst_n = 1'b1;
    for (int k = 0; k < 35; k++) begin
      valid = vec[k].valid;
      data  = vec[k].data;
      step();
      check("table_59", k, obs[0], vec[k].exp);
    end

    do_reset();
    l2    = 16 + 1 + GAP;
    valid = 1'b1;
    data  = 8'hA5;
    for (int k = 0; k <= l2 + 18; k++) begin
      step();
      if (k < l2) begin
        e = exp_obs(2, 8'hA5, k);
      end else begin
        e = exp_obs(2, 8'h3C, k - l2);
        if (k == l2 && GAP == 0) e.done = 1'b1;
      end
      check("b2b", k, obs[1], e);
      if (k == 0)  data  = 8'h3C;
      if (k == l2) valid = 1'b0;
    end

    do_reset();
    valid = 1'b1;
    data  = 8'hC3;
    for (int k = 0; k <= 14; k++) begin
      step();
      check("abort_pre", k, obs[0], exp_obs(4, 8'hC3, k));
      if (k == 0) begin
        valid = 1'b0;
        data  = 8'h00;
      end
    end
    rst_n = 1'b0;
    valid = 1'b1;
    step();
    check("abort_rst", 0, obs[0], RST_OBS);
    rst_n = 1'b1;
    valid = 1'b0;
    step();
    check("abort_nodone", 1, obs[0], RST_OBS);
    word_seq("after_abort_f0", 0, 4, 8'hF0);

    do_reset();
    word_seq("div1_81", 2, 1, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
